// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: reset vector, NOP encoding, fetch FSM states
// and a saturating increment used by the performance counters.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEF  = 32'hBFC0_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HOLD  = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;

  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);

endinterface

// File: rtl/fetch_stage_flopenrc.sv
// Resettable, enabled, synchronously clearable register used for the IF/ID latch.
module flopenrc #(
  parameter int               WIDTH   = 65,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  // clear wins over enable so a flush lands even while the stage is stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          data_q <= RST_VAL;
    else if (clear_i) data_q <= RST_VAL;
    else if (en_i)    data_q <= d_i;
  end

  assign q_o = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage + IF/ID register: PC, imem req/ack handshake, next-PC select.
// Optional FETCH_PERF_EN builds the fetch/wait performance counters.
//
// state   | meaning
// S_FETCH | request outstanding at pcF, waiting for or taking the ack
// S_HOLD  | word already received but stage stalled; word kept in buf
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stallF,
  input  logic                 stallD,
  input  logic                 flushD,
  input  logic                 pcsrcD,
  input  logic                 jumpD,
  input  logic [31:0]          pcbranchD,
  input  logic [31:0]          pcjumpD,
  fetch_stage_if.master        imem,
  output logic                 imem_stallF,
  output logic [31:0]          pcF,
  output logic [31:0]          instrD,
  output logic [31:0]          pcplus4D,
  output logic                 validD,
  output logic [31:0]          perf_fetch,
  output logic [31:0]          perf_wait
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  instr_f, pc_plus4, pc_next;
  logic         done, advance;
  logic [64:0]  ifid_d, ifid_q;

  assign done     = ((state_q == S_FETCH) & imem.ack) | (state_q == S_HOLD);
  assign advance  = done & ~stallF;
  assign instr_f  = (state_q == S_HOLD) ? buf_q : imem.rdata;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_next  = jumpD ? pcjumpD : (pcsrcD ? pcbranchD : pc_plus4);

  assign imem.req    = (state_q == S_FETCH);
  assign imem.addr   = pc_q;
  assign imem_stallF = (state_q == S_FETCH) & ~imem.ack;
  assign pcF         = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // Once the word is in hand, a stall parks it in buf instead of re-requesting
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    if (advance) begin
      state_d = S_FETCH;
      pc_d    = pc_next;
    end else if (done && (state_q == S_FETCH)) begin
      state_d = S_HOLD;
      buf_d   = imem.rdata;
    end
  end

  assign ifid_d = {advance, pc_plus4, advance ? instr_f : NOP_INSTR};

  flopenrc #(
    .WIDTH   (65),
    .RST_VAL ({1'b0, 32'h0000_0000, NOP_INSTR})
  ) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .en_i    (~stallD),
    .clear_i (flushD),
    .d_i     (ifid_d),
    .q_o     (ifid_q)
  );

  assign validD   = ifid_q[64];
  assign pcplus4D = ifid_q[63:32];
  assign instrD   = ifid_q[31:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_wait_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_q <= '0;
      perf_wait_q  <= '0;
    end else begin
      if (advance)     perf_fetch_q <= sat_inc(perf_fetch_q);
      if (imem_stallF) perf_wait_q  <= sat_inc(perf_wait_q);
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_wait  = perf_wait_q;
`else
  assign perf_fetch = '0;
  assign perf_wait  = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus a randomized run against a
// word-level reference model with a random-latency instruction memory.
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk, rst, stallF, stallD, flushD, pcsrcD, jumpD;
  logic [31:0] pcbranchD, pcjumpD;
  logic        imem_stallF, validD;
  logic [31:0] pcF, instrD, pcplus4D, perf_fetch, perf_wait;
  int          errors = 0;
  int          checks = 0;

  fetch_stage_if bus ();

  fetch_stage dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD), .flushD(flushD),
    .pcsrcD(pcsrcD), .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
    .imem(bus), .imem_stallF(imem_stallF), .pcF(pcF), .instrD(instrD),
    .pcplus4D(pcplus4D), .validD(validD), .perf_fetch(perf_fetch), .perf_wait(perf_wait)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] memw(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (pcF !== RST_PC) begin errors++; $display("FAIL reset_pc: got %h exp %h", pcF, RST_PC); end
    checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b exp 1", bus.req); end
    checks++; if ({validD, instrD, pcplus4D} !== 65'd0) begin errors++; $display("FAIL reset_ifid: got %b %h %h exp 0", validD, instrD, pcplus4D); end
    checks++; if ({perf_fetch, perf_wait} !== 64'd0) begin errors++; $display("FAIL reset_perf: got %h %h exp 0", perf_fetch, perf_wait); end
    rst = 0;
  endtask

  task automatic test_zero_wait();
    logic [31:0] a;
    for (int i = 0; i < 3; i++) begin
      a = RST_PC + 32'(4 * i);
      checks++; if (bus.addr !== a) begin errors++; $display("FAIL zw_addr: got %h exp %h", bus.addr, a); end
      bus.ack = 1; bus.rdata = memw(a);
      #1;
      checks++; if (imem_stallF !== 1'b0) begin errors++; $display("FAIL zw_stall: got %b exp 0", imem_stallF); end
      cyc();
      checks++; if ({validD, instrD, pcplus4D} !== {1'b1, memw(a), a + 32'd4}) begin
        errors++; $display("FAIL zw_ifid: got %b %h %h exp 1 %h %h", validD, instrD, pcplus4D, memw(a), a + 32'd4); end
    end
    bus.ack = 0;
    checks++; if (perf_fetch !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL zw_perf_fetch: got %0d exp %0d", perf_fetch, PERF ? 3 : 0); end
  endtask

  task automatic test_wait_states();
    for (int i = 0; i < 3; i++) begin
      bus.ack = 0; bus.rdata = 32'hDEAD_0000 + 32'(i);
      #1;
      checks++; if ({imem_stallF, bus.addr} !== {1'b1, RST_PC + 32'hC}) begin
        errors++; $display("FAIL ws_wait: got %b %h exp 1 %h", imem_stallF, bus.addr, RST_PC + 32'hC); end
      cyc();
      checks++; if (validD !== 1'b0) begin errors++; $display("FAIL ws_bubble: got %b exp 0", validD); end
    end
    bus.ack = 1; bus.rdata = memw(RST_PC + 32'hC);
    cyc();
    bus.ack = 0;
    checks++; if ({validD, instrD, pcF} !== {1'b1, memw(RST_PC + 32'hC), RST_PC + 32'h10}) begin
      errors++; $display("FAIL ws_done: got %b %h %h", validD, instrD, pcF); end
    checks++; if (perf_wait !== (PERF ? 32'd3 : 32'd0)) begin errors++; $display("FAIL ws_perf_wait: got %0d exp %0d", perf_wait, PERF ? 3 : 0); end
  endtask

  task automatic test_hold();
    bus.ack = 1; bus.rdata = memw(RST_PC + 32'h10); stallF = 1;
    cyc();
    bus.ack = 0; bus.rdata = 32'hDEAD_BEEF;
    checks++; if ({bus.req, pcF} !== {1'b0, RST_PC + 32'h10}) begin errors++; $display("FAIL hold_1: got %b %h", bus.req, pcF); end
    cyc();
    checks++; if ({bus.req, pcF} !== {1'b0, RST_PC + 32'h10}) begin errors++; $display("FAIL hold_2: got %b %h", bus.req, pcF); end
    stallF = 0;
    #1;
    checks++; if (imem_stallF !== 1'b0) begin errors++; $display("FAIL hold_stall: got %b exp 0", imem_stallF); end
    cyc();
    checks++; if ({validD, instrD, pcF, bus.req} !== {1'b1, memw(RST_PC + 32'h10), RST_PC + 32'h14, 1'b1}) begin
      errors++; $display("FAIL hold_release: got %b %h %h %b", validD, instrD, pcF, bus.req); end
    checks++; if (perf_fetch !== (PERF ? 32'd5 : 32'd0)) begin errors++; $display("FAIL hold_perf: got %0d exp %0d", perf_fetch, PERF ? 5 : 0); end
  endtask

  task automatic test_redirect();
    bus.ack = 1; bus.rdata = memw(RST_PC + 32'h14); pcsrcD = 1; pcbranchD = 32'hBFC0_0040;
    cyc();
    checks++; if (bus.addr !== 32'hBFC0_0040) begin errors++; $display("FAIL br_addr: got %h exp BFC00040", bus.addr); end
    jumpD = 1; pcjumpD = 32'h8000_0000; bus.rdata = memw(32'hBFC0_0040);
    cyc();
    checks++; if ({pcF, instrD, pcplus4D} !== {32'h8000_0000, memw(32'hBFC0_0040), 32'hBFC0_0044}) begin
      errors++; $display("FAIL jmp_prio: got %h %h %h", pcF, instrD, pcplus4D); end
    pcsrcD = 0; pcjumpD = 32'hFFFF_FFFC; bus.rdata = memw(32'h8000_0000);
    cyc();
    jumpD = 0; bus.rdata = memw(32'hFFFF_FFFC);
    cyc();
    bus.ack = 0;
    checks++; if ({pcF, pcplus4D, validD} !== {32'h0, 32'h0, 1'b1}) begin errors++; $display("FAIL pc_wrap: got %h %h %b", pcF, pcplus4D, validD); end
  endtask

  task automatic test_flush_stall();
    bus.ack = 1; bus.rdata = memw(32'h0); stallD = 1;
    cyc();
    checks++; if ({instrD, pcF} !== {memw(32'hFFFF_FFFC), 32'h4}) begin errors++; $display("FAIL stallD_hold: got %h %h", instrD, pcF); end
    flushD = 1; bus.rdata = memw(32'h4);
    cyc();
    bus.ack = 0; stallD = 0; flushD = 0;
    checks++; if ({validD, instrD, pcplus4D} !== 65'd0) begin errors++; $display("FAIL flush_prio: got %b %h %h exp 0", validD, instrD, pcplus4D); end
  endtask

  task automatic test_rst_mid_fetch();
    rst = 1;
    cyc();
    rst = 0;
    bus.ack = 1;
    for (int i = 0; i < 4; i++) begin bus.rdata = memw(bus.addr); cyc(); end
    bus.ack = 0;
    cyc();
    checks++; if ({imem_stallF, bus.addr} !== {1'b1, 32'hBFC0_0010}) begin errors++; $display("FAIL rst_setup: got %b %h", imem_stallF, bus.addr); end
    rst = 1;
    #2;
    checks++; if ({pcF, validD, instrD, pcplus4D} !== {RST_PC, 65'd0}) begin errors++; $display("FAIL rst_async: got %h %b %h %h", pcF, validD, instrD, pcplus4D); end
    checks++; if ({perf_fetch, perf_wait} !== 64'd0) begin errors++; $display("FAIL rst_perf: got %h %h exp 0", perf_fetch, perf_wait); end
    @(negedge clk);
    bus.ack = 1; bus.rdata = 32'hDEAD_BEEF;
    cyc();
    checks++; if ({pcF, validD} !== {RST_PC, 1'b0}) begin errors++; $display("FAIL rst_late_ack: got %h %b", pcF, validD); end
    bus.ack = 0; rst = 0;
    #1;
    checks++; if ({bus.req, bus.addr, imem_stallF} !== {1'b1, RST_PC, 1'b1}) begin errors++; $display("FAIL rst_rereq: got %b %h %b", bus.req, bus.addr, imem_stallF); end
    bus.ack = 1; bus.rdata = memw(RST_PC);
    cyc();
    bus.ack = 0;
    checks++; if ({instrD, pcF} !== {memw(RST_PC), RST_PC + 32'd4}) begin errors++; $display("FAIL rst_first: got %h %h", instrD, pcF); end
  endtask

  task automatic test_random(input int n);
    logic [31:0] m_pc, m_buf, m_instrD, m_pc4D, m_fetch, m_wait, instr_f;
    logic        m_have, m_validD, done, adv;
    int          wait_left;
    rst = 1;
    cyc();
    rst = 0;
    m_pc = RST_PC; m_have = 0; m_buf = 0; m_instrD = 0; m_pc4D = 0; m_validD = 0; m_fetch = 0; m_wait = 0;
    wait_left = $urandom_range(0, 3);
    for (int i = 0; i < n; i++) begin
      checks++; if ({pcF, bus.addr, bus.req} !== {m_pc, m_pc, ~m_have}) begin
        errors++; $display("FAIL rnd_pc[%0d]: got %h %h %b exp %h %b", i, pcF, bus.addr, bus.req, m_pc, ~m_have); end
      checks++; if ({validD, instrD, pcplus4D} !== {m_validD, m_instrD, m_pc4D}) begin
        errors++; $display("FAIL rnd_ifid[%0d]: got %b %h %h exp %b %h %h", i, validD, instrD, pcplus4D, m_validD, m_instrD, m_pc4D); end
      checks++; if ({perf_fetch, perf_wait} !== (PERF ? {m_fetch, m_wait} : 64'd0)) begin
        errors++; $display("FAIL rnd_perf[%0d]: got %0d %0d exp %0d %0d", i, perf_fetch, perf_wait, m_fetch, m_wait); end
      stallF = ($urandom_range(0, 3) == 0); stallD = ($urandom_range(0, 7) == 0);
      flushD = ($urandom_range(0, 15) == 0);
      pcsrcD = ($urandom_range(0, 3) == 0); jumpD = ($urandom_range(0, 5) == 0);
      pcbranchD = $urandom; pcjumpD = $urandom;
      if (bus.req && wait_left == 0) begin
        bus.ack = 1; bus.rdata = memw(bus.addr); wait_left = $urandom_range(0, 3);
      end else begin
        bus.ack = 0; bus.rdata = $urandom;
        if (bus.req) wait_left--;
      end
      #1;
      checks++; if (imem_stallF !== (~m_have & ~bus.ack)) begin
        errors++; $display("FAIL rnd_stallF[%0d]: got %b exp %b", i, imem_stallF, ~m_have & ~bus.ack); end
      // what the stage owns this cycle, and whether it moves on
      done    = m_have | bus.ack;
      instr_f = m_have ? m_buf : bus.rdata;
      adv     = done & ~stallF;
      if (flushD) begin m_instrD = 0; m_pc4D = 0; m_validD = 0; end
      else if (!stallD) begin m_instrD = adv ? instr_f : 32'h0; m_pc4D = m_pc + 32'd4; m_validD = adv; end
      if (!done && m_wait != 32'hFFFF_FFFF) m_wait++;
      if (adv) begin
        if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
        m_pc   = jumpD ? pcjumpD : pcsrcD ? pcbranchD : m_pc + 32'd4;
        m_have = 0;
      end else if (done) begin
        m_have = 1; m_buf = instr_f;
      end
      cyc();
    end
    bus.ack = 0; stallF = 0; stallD = 0; flushD = 0; pcsrcD = 0; jumpD = 0;
  endtask

  initial begin
    clk = 0; rst = 1; stallF = 0; stallD = 0; flushD = 0; pcsrcD = 0; jumpD = 0;
    pcbranchD = 0; pcjumpD = 0; bus.ack = 0; bus.rdata = 0;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_hold();
    test_redirect();
    test_flush_stall();
    test_rst_mid_fetch();
    test_random(500);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
